// File: rtl/mips_defs.sv
// Shared MIPS definitions: opcodes, ALU/mux encodings and multicycle control states.
package mips_defs;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RST, FETCH, DECODE, R_EXEC, R_WB, I_EXEC, I_WB, MEM_ADDR,
        MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, TRAP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_LW, CLS_SW, CLS_IALU, CLS_BEQ, CLS_J, CLS_ILL
    } opClass_t;

endpackage

// File: rtl/op_class_decode.sv
// Combinational opcode classifier: instruction class, I-type ALUOp and illegal flag.
module op_class_decode
    import mips_defs::*;
(
    input  logic [5:0] opCode,
    output opClass_t   opClass,
    output logic [2:0] iAluOp,
    output logic       illegal
);

    always_comb begin
        opClass = CLS_ILL;
        iAluOp  = ALU_ADD;
        illegal = 1'b0;
        unique case (opCode)
            OP_RTYPE: opClass = CLS_R;
            OP_LW:    opClass = CLS_LW;
            OP_SW:    opClass = CLS_SW;
            OP_BEQ:   opClass = CLS_BEQ;
            OP_J:     opClass = CLS_J;
            OP_ADDI: begin opClass = CLS_IALU; iAluOp = ALU_ADD; end
            OP_SLTI: begin opClass = CLS_IALU; iAluOp = ALU_SLT; end
            OP_ANDI: begin opClass = CLS_IALU; iAluOp = ALU_AND; end
            OP_ORI:  begin opClass = CLS_IALU; iAluOp = ALU_OR;  end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore-decoded datapath controls, handshake-qualified
// PC/IR writes in FETCH, sticky trap and a retired-instruction counter.
module multicycle_ctrl
    import mips_defs::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       OpCode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             PCWrite,
    output logic             Trap,
    output logic [CNT_W-1:0] InstrCount
);

    state_t     state, nextState;
    opClass_t   decClass, classQ;
    logic [2:0] decAluOp, iAluOpQ;
    logic       decIllegal;
    logic       retire;

    op_class_decode u_decode (
        .opCode  (OpCode),
        .opClass (decClass),
        .iAluOp  (decAluOp),
        .illegal (decIllegal)
    );

    // Every path into FETCH except the reset exit and a FETCH wait completes an instruction.
    assign retire = (nextState == FETCH) && (state != S_RST) && (state != FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_RST;
            classQ     <= CLS_R;
            iAluOpQ    <= ALU_ADD;
            InstrCount <= '0;
        end else begin
            state <= nextState;
            if (state == DECODE) begin
                classQ  <= decClass;
                iAluOpQ <= decAluOp;
            end
            if (retire) InstrCount <= InstrCount + CNT_W'(1);
        end
    end

    always_comb begin
        nextState = state;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemToReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RT;
        ALUOp     = ALU_ADD;
        PCSource  = PC_ALU;
        PCWrite   = 1'b0;
        Trap      = 1'b0;
        unique case (state)
            S_RST: nextState = FETCH;
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
                if (MemReady) nextState = DECODE;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                if (decIllegal) begin
                    nextState = TRAP;
                end else begin
                    unique case (decClass)
                        CLS_R:          nextState = R_EXEC;
                        CLS_LW, CLS_SW: nextState = MEM_ADDR;
                        CLS_IALU:       nextState = I_EXEC;
                        CLS_BEQ:        nextState = BRANCH;
                        CLS_J:          nextState = JUMP;
                        default:        nextState = TRAP;
                    endcase
                end
            end
            R_EXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALU_RTYPE;
                nextState = R_WB;
            end
            R_WB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            I_EXEC: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                ALUOp     = iAluOpQ;
                nextState = I_WB;
            end
            I_WB: begin
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            MEM_ADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                nextState = (classQ == CLS_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (MemReady) nextState = MEM_WB;
            end
            MEM_WB: begin
                MemToReg  = 1'b1;
                RegWrite  = 1'b1;
                nextState = FETCH;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (MemReady) nextState = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUOp     = ALU_SUB;
                PCSource  = PC_ALUOUT;
                PCWrite   = Zero;
                nextState = FETCH;
            end
            JUMP: begin
                PCSource  = PC_JUMP;
                PCWrite   = 1'b1;
                nextState = FETCH;
            end
            TRAP:    Trap = 1'b1;
            default: nextState = S_RST;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench: stimulus pushes per-cycle expected controls/count, a negedge monitor checks.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] OpCode;
    logic       Zero, MemReady;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic       PCWrite, Trap;
    logic [3:0] InstrCount;

    multicycle_ctrl #(.CNT_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .OpCode     (OpCode),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegDst     (RegDst),
        .MemToReg   (MemToReg),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSource   (PCSource),
        .PCWrite    (PCWrite),
        .Trap       (Trap),
        .InstrCount (InstrCount)
    );

    always #5 clk = ~clk;

    string       nameQ[$];
    logic [16:0] cwQ[$];
    logic [3:0]  cntQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  expCnt = 4'd0;

    logic [16:0] actCw;
    assign actCw = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA,
                    ALUSrcB, ALUOp, PCSource, PCWrite, Trap};

    function automatic logic [16:0] cw(input logic iord, mr, mw, irw, rdst, m2r, rw, srca,
                                       input logic [1:0] srcb, input logic [2:0] aop,
                                       input logic [1:0] pcs, input logic pcw, trap);
        return {iord, mr, mw, irw, rdst, m2r, rw, srca, srcb, aop, pcs, pcw, trap};
    endfunction

    always @(negedge clk) begin
        while (cwQ.size() > 0) begin
            string       nm;
            logic [16:0] eCw;
            logic [3:0]  eCnt;
            nm   = nameQ.pop_front();
            eCw  = cwQ.pop_front();
            eCnt = cntQ.pop_front();
            checks++;
            if (actCw !== eCw) begin
                errors++;
                $display("FAIL %s ctrl: got %b expected %b", nm, actCw, eCw);
            end
            checks++;
            if (InstrCount !== eCnt) begin
                errors++;
                $display("FAIL %s count: got %0d expected %0d", nm, InstrCount, eCnt);
            end
        end
    end

    task automatic push(input string nm, input logic [16:0] e, input logic [3:0] c);
        nameQ.push_back(nm);
        cwQ.push_back(e);
        cntQ.push_back(c);
    endtask

    // One clock cycle: drive inputs, queue the expectation for this cycle, advance.
    task automatic cyc(input string nm, input logic [5:0] op, input logic rdy, input logic z,
                       input logic [16:0] e, input logic ret);
        OpCode   = op;
        MemReady = rdy;
        Zero     = z;
        #1;
        push(nm, e, expCnt);
        @(posedge clk);
        #1;
        if (ret) expCnt = expCnt + 4'd1;
    endtask

    logic [16:0] cFetch, cFWait, cDec, cRex, cRwb, cIwb, cMaddr, cMrd, cMwb, cMwr;
    logic [16:0] cBr1, cBr0, cJmp, cTrap, cZero;

    initial begin
        cFetch = cw(0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 1, 0);
        cFWait = cw(0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0, 0);
        cDec   = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 0, 0);
        cRex   = cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 0, 0);
        cRwb   = cw(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0);
        cIwb   = cw(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0);
        cMaddr = cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0, 0);
        cMrd   = cw(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
        cMwb   = cw(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0);
        cMwr   = cw(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0);
        cBr1   = cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 1, 0);
        cBr0   = cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 0, 0);
        cJmp   = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 1, 0);
        cTrap  = cw(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1);
        cZero  = '0;

        rst_n = 1'b0; OpCode = 6'b0; MemReady = 1'b1; Zero = 1'b0;
        #1;
        push("reset", cZero, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // R-type; OpCode is garbage after DECODE to prove the class is latched
        cyc("r.fetch",  6'b000000, 1, 0, cFetch, 0);
        cyc("r.decode", 6'b000000, 1, 0, cDec,   0);
        cyc("r.exec",   6'b111111, 1, 0, cRex,   0);
        cyc("r.wb",     6'b100011, 1, 0, cRwb,   1);

        cyc("addi.fetch",  6'b0,      1, 0, cFetch, 0);
        cyc("addi.decode", 6'b001000, 1, 0, cDec,   0);
        cyc("addi.exec",   6'b0,      1, 0, cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0, 0), 0);
        cyc("addi.wb",     6'b0,      1, 0, cIwb,   1);

        cyc("ori.fetch",  6'b0,      1, 0, cFetch, 0);
        cyc("ori.decode", 6'b001101, 1, 0, cDec,   0);
        cyc("ori.exec",   6'b001010, 1, 0, cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b110, 2'b00, 0, 0), 0);
        cyc("ori.wb",     6'b0,      1, 0, cIwb,   1);

        cyc("slti.fetch",  6'b0,      1, 0, cFetch, 0);
        cyc("slti.decode", 6'b001010, 1, 0, cDec,   0);
        cyc("slti.exec",   6'b001101, 1, 0, cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b111, 2'b00, 0, 0), 0);
        cyc("slti.wb",     6'b0,      1, 0, cIwb,   1);

        cyc("andi.fetch",  6'b0,      1, 0, cFetch, 0);
        cyc("andi.decode", 6'b001100, 1, 0, cDec,   0);
        cyc("andi.exec",   6'b0,      1, 0, cw(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b100, 2'b00, 0, 0), 0);
        cyc("andi.wb",     6'b0,      1, 0, cIwb,   1);

        // lw with two wait cycles in MEM_RD: 7 cycles total
        cyc("lw.fetch",  6'b0,      1, 0, cFetch, 0);
        cyc("lw.decode", 6'b100011, 1, 0, cDec,   0);
        cyc("lw.addr",   6'b101011, 1, 0, cMaddr, 0);
        cyc("lw.rd0",    6'b0,      0, 0, cMrd,   0);
        cyc("lw.rd1",    6'b0,      0, 0, cMrd,   0);
        cyc("lw.rd2",    6'b0,      1, 0, cMrd,   0);
        cyc("lw.wb",     6'b0,      1, 0, cMwb,   1);

        // sw with one FETCH wait cycle
        cyc("sw.fwait",  6'b0,      0, 0, cFWait, 0);
        cyc("sw.fetch",  6'b0,      1, 0, cFetch, 0);
        cyc("sw.decode", 6'b101011, 1, 0, cDec,   0);
        cyc("sw.addr",   6'b100011, 1, 0, cMaddr, 0);
        cyc("sw.wr",     6'b0,      1, 0, cMwr,   1);

        cyc("beq1.fetch",  6'b0,      1, 1, cFetch, 0);
        cyc("beq1.decode", 6'b000100, 1, 1, cDec,   0);
        cyc("beq1.branch", 6'b0,      1, 1, cBr1,   1);
        cyc("beq0.fetch",  6'b0,      1, 0, cFetch, 0);
        cyc("beq0.decode", 6'b000100, 1, 0, cDec,   0);
        cyc("beq0.branch", 6'b0,      1, 0, cBr0,   1);

        // 16 jumps: 4-bit counter passes 15 -> 0 and lands back where it started
        for (int i = 0; i < 16; i++) begin
            cyc("j.fetch",  6'b0,      1, 0, cFetch, 0);
            cyc("j.decode", 6'b000010, 1, 0, cDec,   0);
            cyc("j.jump",   6'b0,      1, 0, cJmp,   1);
        end
        cyc("j.after", 6'b0, 0, 0, cFWait, 0);
        cyc("j.after2", 6'b0, 1, 0, cFetch, 0);

        // Reset mid MEM_WR: outputs clear without a clock edge, count returns to 0
        cyc("sw2.decode", 6'b101011, 1, 0, cDec,   0);
        cyc("sw2.addr",   6'b0,      1, 0, cMaddr, 0);
        cyc("sw2.wait",   6'b0,      0, 0, cMwr,   0);
        rst_n    = 1'b0;
        MemReady = 1'b1;
        #1;
        expCnt = 4'd0;
        push("rst.async", cZero, expCnt);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("rst.fetch",  6'b0, 1, 0, cFetch, 0);
        cyc("rst.decode", 6'b0, 1, 0, cDec,   0);
        cyc("rst.exec",   6'b0, 1, 0, cRex,   0);
        cyc("rst.wb",     6'b0, 1, 0, cRwb,   1);

        // Illegal opcode: TRAP is absorbing and the count freezes
        cyc("trap.fetch",  6'b0,      1, 0, cFetch, 0);
        cyc("trap.decode", 6'b111111, 1, 0, cDec,   0);
        for (int i = 0; i < 20; i++) begin
            cyc("trap.hold", 6'(i), i[0], 1, cTrap, 0);
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the MIPS datapath. It sequences one shared ALU, one unified instruction/data memory and the register file through the fetch, decode, execute, memory and writeback steps. Control outputs are Moore-decoded from a state register, except the handshake-qualified PC and IR write enables. The block replaces the single-cycle opcode decoder in front of the same datapath and keeps its opcode set and ALUOp encoding, with `sw` added.

## Interface
Parameters:
- `CNT_W`, 16, width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `OpCode`  in  6  IR[31:26]; sampled only in DECODE.
- `Zero`  in  1  ALU zero flag; used only in BRANCH.
- `MemReady`  in  1  memory completes the current access this cycle.
- `IorD`  out  1  memory address source: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  memory read request.
- `MemWrite`  out  1  memory write request.
- `IRWrite`  out  1  load the instruction register.
- `RegDst`  out  1  write register: 1 = rd, 0 = rt.
- `MemToReg`  out  1  writeback data: 1 = MDR, 0 = ALUOut.
- `RegWrite`  out  1  register file write enable.
- `ALUSrcA`  out  1  ALU A input: 0 = PC, 1 = rs.
- `ALUSrcB`  out  2  ALU B input: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp`  out  3  same encoding as the existing ALU control: add 000, sub 001, R-type 010, and 100, or 110, slt 111.
- `PCSource`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `PCWrite`  out  1  PC write enable; the branch condition is already folded in.
- `Trap`  out  1  sticky flag: illegal opcode seen.
- `InstrCount`  out  CNT_W  count of retired instructions.

## Operation
- States:
  - `S_RST`: entered only via reset.
  - `FETCH`: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSource=00. IRWrite=PCWrite=MemReady. Stays in FETCH until MemReady, then goes to DECODE.
  - `DECODE`: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (computes the branch target).
    - 000000 → R_EXEC.
    - 100011 or 101011 → MEM_ADDR.
    - 001000, 001010, 001100, 001101 → I_EXEC.
    - 000100 → BRANCH.
    - 000010 → JUMP.
    - Any other opcode → TRAP.
  - `R_EXEC`: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next: R_WB.
  - `R_WB`: RegDst=1, MemToReg=0, RegWrite=1. Next: FETCH.
  - `I_EXEC`: ALUSrcA=1, ALUSrcB=10. ALUOp = 000 (addi), 111 (slti), 100 (andi) or 110 (ori). Next: I_WB.
  - `I_WB`: RegDst=0, MemToReg=0, RegWrite=1. Next: FETCH.
  - `MEM_ADDR`: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next: MEM_RD for lw, MEM_WR for sw.
  - `MEM_RD`: MemRead=1, IorD=1. Stays until MemReady, then goes to MEM_WB.
  - `MEM_WB`: RegDst=0, MemToReg=1, RegWrite=1. Next: FETCH.
  - `MEM_WR`: MemWrite=1, IorD=1. Stays until MemReady, then goes to FETCH.
  - `BRANCH`: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01, PCWrite=Zero. Next: FETCH.
  - `JUMP`: PCSource=10, PCWrite=1. Next: FETCH.
  - `TRAP`: all enables 0, Trap=1. Absorbing; exits only on reset.
- Every output not listed for a state is 0.
- The opcode-to-class decode is held in a latched class register loaded in DECODE, so OpCode changes after DECODE have no effect.
- Instruction retirement:
  - An instruction retires on entry to FETCH from R_WB, I_WB, MEM_WB, MEM_WR, BRANCH or JUMP.
  - Retirement increments InstrCount, which wraps modulo 2^CNT_W with no saturation.

## Timing
- Reset (asynchronous, while rst_n=0):
  - State goes to S_RST; every output is 0; InstrCount=0; Trap=0.
  - First rising edge with rst_n=1 moves S_RST → FETCH.
- Reset asserted mid-instruction aborts the instruction at once. No partial writeback occurs after the assertion, and the aborted instruction does not increment InstrCount.
- Cycles per instruction with MemReady=1 on the first cycle of every access:

  | Instruction | Cycles |
  |---|---|
  | R-type, I-type ALU, sw | 4 |
  | lw | 5 |
  | beq, j | 3 |

  Each cycle MemReady is held low adds one cycle in FETCH, MEM_RD or MEM_WR.
- Memory handshake:
  - A request (MemRead or MemWrite) stays asserted with a stable IorD until the cycle MemReady=1.
  - MemReady is ignored in every other state.
- IRWrite and PCWrite in FETCH are Mealy outputs on MemReady, so they pulse for exactly the completing cycle.
- PCWrite in BRANCH follows Zero combinationally, one cycle.
- Trap rises on the first cycle in TRAP and holds until reset. InstrCount freezes while in TRAP.

## Structure
- Shared `mips_defs` package holds:
  - opcode constants (R, lw, sw, beq, j, addi, slti, andi, ori);
  - ALUOp codes;
  - ALUSrcB and PCSource encodings;
  - the state enumeration.
- Sub-module `op_class_decode` (combinational) maps OpCode to {class, I-type ALUOp, illegal}. It is instantiated once, feeding DECODE.

## Test plan
- Reset released, MemReady=1, OpCode=000000:
  - FETCH on cycle 1, then DECODE, R_EXEC, R_WB.
  - RegWrite=1 and RegDst=1 in cycle 4.
  - InstrCount goes to 1 on the next edge.
- lw (100011) with MemReady low for 2 cycles in MEM_RD: MemRead=1 and IorD=1 held for 3 cycles, then MEM_WB with MemToReg=1; total 7 cycles.
- beq with Zero=1, then beq with Zero=0: PCWrite=1 with PCSource=01 in BRANCH for the first and PCWrite=0 for the second; each takes 3 cycles.
- OpCode=111111 in DECODE: TRAP entered; Trap=1 held for 20 cycles; all enables 0; InstrCount unchanged.
- rst_n pulled low mid MEM_WR: all outputs 0 asynchronously; after release, FETCH is re-entered and InstrCount=0.
- CNT_W=4, 16 consecutive j instructions: InstrCount wraps 15 → 0.
